// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller bundle: pipeline status in, register controls out.
// The pipeline side is the master, the controller is the slave.
interface pipeline_hazard_controller_if;
  logic        imem_busywait;
  logic        dmem_busywait;
  logic        mdu_start;
  logic        mdu_done;
  logic        load_use_hazard;
  logic        branch_taken;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_ma_en;
  logic        ma_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_ma_bubble;
  logic        mdu_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output imem_busywait, dmem_busywait,
    output mdu_start, mdu_done,
    output load_use_hazard, branch_taken,
    input  pc_en, if_id_en, id_ex_en,
    input  ex_ma_en, ma_wb_en,
    input  if_id_flush, id_ex_flush,
    input  ex_ma_bubble,
    input  mdu_timeout, stall_cycles
  );

  modport slave (
    input  imem_busywait, dmem_busywait,
    input  mdu_start, mdu_done,
    input  load_use_hazard, branch_taken,
    output pc_en, if_id_en, id_ex_en,
    output ex_ma_en, ma_wb_en,
    output if_id_flush, id_ex_flush,
    output ex_ma_bubble,
    output mdu_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline.
// Holds MUL/DIV sequencing in a small FSM and counts stall cycles.
module pipeline_hazard_controller #(
  parameter int MDU_TIMEOUT = 40,
  parameter int TIMER_W     = 6
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    RUN,
    MDU_WAIT,
    MDU_DRAIN
  } state_t;

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic               done_pending, dp_n;
  logic               mdu_timeout, to_n;
  logic [31:0]        stall_cycles;

  logic pc_en, if_id_en, id_ex_en;
  logic ex_ma_en, ma_wb_en;
  logic if_id_flush, id_ex_flush;
  logic ex_ma_bubble;
  logic use_front;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_ma_en     = 1'b1;
    ma_wb_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_ma_bubble = 1'b0;
    use_front    = 1'b0;
    state_n      = state;
    timer_n      = timer;
    dp_n         = done_pending | hz.mdu_done;
    to_n         = mdu_timeout;
    if (rst || hz.dmem_busywait) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
      ex_ma_en = 1'b0;
      ma_wb_en = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (hz.mdu_start) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_ma_bubble = 1'b1;
            state_n      = MDU_WAIT;
            timer_n      = TIMER_W'(1);
            dp_n         = 1'b0;
          end else begin
            use_front = 1'b1;
          end
        end
        MDU_WAIT: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_ma_bubble = 1'b1;
          if (hz.mdu_done || done_pending) begin
            state_n = MDU_DRAIN;
            dp_n    = 1'b0;
          end else if (timer == TIMER_W'(MDU_TIMEOUT)) begin
            state_n = MDU_DRAIN;
            to_n    = 1'b1;
          end else begin
            timer_n = timer + TIMER_W'(1);
          end
        end
        MDU_DRAIN: begin
          // The M-op is still in EX here, so its start is not a new op
          use_front = 1'b1;
          state_n   = RUN;
        end
        default: state_n = RUN;
      endcase
      if (use_front) begin
        unique case (1'b1)
          hz.branch_taken: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end
          hz.load_use_hazard && !hz.branch_taken: begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
          hz.imem_busywait && !hz.branch_taken
            && !hz.load_use_hazard: begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      timer        <= '0;
      done_pending <= 1'b0;
      mdu_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      done_pending <= dp_n;
      mdu_timeout  <= to_n;
      if (!pc_en && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.ex_ma_en     = ex_ma_en;
  assign hz.ma_wb_en     = ma_wb_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_ma_bubble = ex_ma_bubble;
  assign hz.mdu_timeout  = mdu_timeout;
  assign hz.stall_cycles = stall_cycles;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32IM pipeline.
- Consumes memory busywaits, the multi-cycle MDU handshake, load-use detection and branch resolution.
- Drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MA and MA/WB registers.
- Multi-cycle MUL/DIV sequencing is held in a small FSM; a perf counter records stall cycles.

Parameters:
MDU_TIMEOUT, 40, max MDU_WAIT cycles before forced drain and sticky error
TIMER_W, 6, width of MDU wait timer (must satisfy 2^TIMER_W > MDU_TIMEOUT)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_busywait  in  1  instruction memory not ready
dmem_busywait  in  1  data memory not ready (access in MA)
mdu_start  in  1  M-extension op present in EX this cycle
mdu_done  in  1  MDU result valid (single-cycle pulse)
load_use_hazard  in  1  ID reads the rd of a load in EX
branch_taken  in  1  EX resolved a taken branch or jump
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
id_ex_en  out  1  ID/EX load enable
ex_ma_en  out  1  EX/MA load enable
ma_wb_en  out  1  MA/WB load enable
if_id_flush  out  1  IF/ID loads NOP on next edge
id_ex_flush  out  1  ID/EX loads NOP on next edge
ex_ma_bubble  out  1  EX/MA loads NOP instead of EX result
mdu_timeout  out  1  sticky: MDU exceeded MDU_TIMEOUT
stall_cycles  out  32  saturating count of cycles with pc_en=0

Behaviour:
- Registered state: fsm state, timer[TIMER_W-1:0], done_pending, mdu_timeout, stall_cycles.
- All control outputs are combinational from state and inputs.
- Reset, synchronous: state=RUN, timer=0, done_pending=0, mdu_timeout=0, stall_cycles=0.
- While rst=1: all enables=0, all flush/bubble=0.
- Reset mid-MDU_WAIT abandons the op and returns to RUN on that edge.
- Defaults: all enables=1, flush/bubble=0.
- Global override, any state: dmem_busywait=1 → all five enables=0, flush/bubble=0, state and timer hold.
- Global override, any state: an mdu_done seen in that cycle sets done_pending.
- RUN, in priority order:
  1. mdu_start: pc_en=if_id_en=id_ex_en=0, ex_ma_bubble=1; next state MDU_WAIT, timer=1. branch_taken, load_use_hazard and imem_busywait are ignored.
  2. branch_taken: if_id_flush=1, id_ex_flush=1, all enables=1. imem_busywait is ignored; the redirect must land.
  3. load_use_hazard: pc_en=if_id_en=0, id_ex_flush=1.
  4. imem_busywait: pc_en=0, if_id_flush=1.
  5. mdu_done with no start: ignored, no effect.
- MDU_WAIT:
  - pc_en=if_id_en=id_ex_en=0, ex_ma_bubble=1; EX/MA and MA/WB advance so older instructions drain.
  - mdu_done or done_pending → MDU_DRAIN; clear done_pending.
  - Else if timer==MDU_TIMEOUT → MDU_DRAIN, set mdu_timeout.
  - Else timer+1.
- MDU_DRAIN, one cycle:
  - Same rules as RUN except mdu_start is ignored, because the same M-op is still in EX.
  - ex_ma_bubble=0, so the MDU result is captured.
  - Next state RUN. If dmem_busywait, remain in MDU_DRAIN.
- stall_cycles increments on each non-reset cycle with pc_en=0 and saturates at 0xFFFFFFFF.
- mdu_timeout clears only on rst.

Test Plan:
- Reset then idle, all inputs 0 → all enables=1 from the first cycle after rst deasserts; stall_cycles stays 0.
- load_use_hazard=1 for one cycle in RUN → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cycles=1.
- mdu_start=1, mdu_done pulsed 5 cycles later → 1 start cycle plus 5 MDU_WAIT cycles with ex_ma_bubble=1, then 1 DRAIN cycle with ex_ma_bubble=0 and all en=1; stall_cycles=6.
- MDU_WAIT with dmem_busywait=1 for 3 cycles and mdu_done pulsed during that window → all enables 0 for 3 cycles, done_pending latched, DRAIN on the cycle after busywait drops.
- mdu_start with mdu_done never asserted, MDU_TIMEOUT=40 → DRAIN after 40 wait cycles; mdu_timeout=1 and stays 1 until rst.
- branch_taken=1 with imem_busywait=1 and load_use_hazard=1 simultaneously → pc_en=1, if_id_flush=1, id_ex_flush=1 (branch wins).
